power_sequencer: RTL and testbench

- Parametrised successor to the board management/power-up block.
- Synchronises and debounces power_good from the BUBBLE SYSTEM board.
- Sequences settle, image-latch, loader handshake and warm-up, then asserts READY (temperature_low) and enables the bubble interface.
- On power loss, drains any in-flight bubble access before disabling. Sits between the host connector, BubbleInterface and SPILoader.

---
 rtl/power_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_power_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/power_sequencer.sv
// ============================================================================
// Module   : power_sequencer
// Purpose  : Debounced power-good sequencer: settle, image latch, loader
//            handshake, warm-up, READY, and bubble-access drain on power loss.
//            Optional build macro IMAGE_HOTSWAP_EN re-latches on DIP change.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module power_sequencer #(
  parameter int SYNC_STAGES          = 3,
  parameter int DEBOUNCE_CYCLES      = 16,
  parameter int SETTLE_CYCLES        = 64,
  parameter int WARMUP_CYCLES        = 128,
  parameter int LOAD_TIMEOUT_CYCLES  = 1024,
  parameter int DRAIN_TIMEOUT_CYCLES = 256,
  parameter int IMAGE_BITS           = 3,
  parameter int CNT_WIDTH            = 29
) (
  input  logic                  master_clock,
  input  logic                  master_reset,
  input  logic                  power_good,
  input  logic [IMAGE_BITS-1:0] image_dip_switch,
  input  logic                  image_load_ack,
  input  logic                  bubble_busy,
  output logic                  temperature_low,
  output logic                  bubble_module_enable,
  output logic [IMAGE_BITS-1:0] image_number,
  output logic                  image_load_req,
  output logic                  seq_fault,
  output logic [2:0]            seq_state
);

  typedef enum logic [2:0] {
    S_OFF    = 3'd0,
    S_SETTLE = 3'd1,
    S_LATCH  = 3'd2,
    S_WARMUP = 3'd3,
    S_RUN    = 3'd4,
    S_DRAIN  = 3'd5,
    S_FAULT  = 3'd6
  } state_t;

  localparam int c_db_w = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [c_db_w-1:0]    c_db_last     = c_db_w'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] c_settle_last = CNT_WIDTH'(SETTLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] c_warm_last   = CNT_WIDTH'(WARMUP_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] c_load_last   = CNT_WIDTH'(LOAD_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] c_drain_last  = CNT_WIDTH'(DRAIN_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] c_cnt_max     = '1;

  state_t                 r_state;
  state_t                 w_next;
  state_t                 w_drain_exit;
  logic                   w_hs_trigger;
  logic [SYNC_STAGES-1:0] r_pg_sync;
  logic [IMAGE_BITS-1:0]  r_dip_sync [SYNC_STAGES];
  logic                   w_pg_synced;
  logic [IMAGE_BITS-1:0]  w_dip_synced;
  logic                   r_pg_int;
  logic [c_db_w-1:0]      r_db_cnt;
  logic [CNT_WIDTH-1:0]   r_cnt;
  logic                   r_temp_low;
  logic                   r_enable_n;
  logic [IMAGE_BITS-1:0]  r_image;
  logic                   r_req;
  logic                   r_fault;

  assign w_pg_synced  = r_pg_sync[SYNC_STAGES-1];
  assign w_dip_synced = r_dip_sync[SYNC_STAGES-1];

  always_ff @(posedge master_clock or posedge master_reset) begin
    if (master_reset) begin
      r_pg_sync <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) r_dip_sync[i] <= '0;
    end else begin
      r_pg_sync     <= {r_pg_sync[SYNC_STAGES-2:0], power_good};
      r_dip_sync[0] <= image_dip_switch;
      for (int i = 1; i < SYNC_STAGES; i++) r_dip_sync[i] <= r_dip_sync[i-1];
    end
  end

  // Any cycle where the synced level agrees with pg_int restarts the count
  always_ff @(posedge master_clock or posedge master_reset) begin
    if (master_reset) begin
      r_pg_int <= 1'b0;
      r_db_cnt <= '0;
    end else if (w_pg_synced != r_pg_int) begin
      if (r_db_cnt == c_db_last) begin
        r_pg_int <= w_pg_synced;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + c_db_w'(1);
      end
    end else begin
      r_db_cnt <= '0;
    end
  end

`ifdef IMAGE_HOTSWAP_EN
  logic [c_db_w-1:0] r_hs_cnt;
  logic              r_hs_pending;
  logic              w_dip_mismatch;

  assign w_dip_mismatch = (~w_dip_synced != r_image);
  assign w_hs_trigger   = (r_state == S_RUN) && w_dip_mismatch && (r_hs_cnt == c_db_last);
  assign w_drain_exit   = (r_hs_pending && r_pg_int) ? S_SETTLE : S_OFF;

  always_ff @(posedge master_clock or posedge master_reset) begin
    if (master_reset) begin
      r_hs_cnt     <= '0;
      r_hs_pending <= 1'b0;
    end else begin
      if ((r_state == S_RUN) && w_dip_mismatch) begin
        if (r_hs_cnt != c_db_last) r_hs_cnt <= r_hs_cnt + c_db_w'(1);
      end else begin
        r_hs_cnt <= '0;
      end
      if (w_hs_trigger && r_pg_int)
        r_hs_pending <= 1'b1;
      else if ((r_state == S_DRAIN) && (w_next != S_DRAIN))
        r_hs_pending <= 1'b0;
    end
  end
`else
  assign w_hs_trigger = 1'b0;
  assign w_drain_exit = S_OFF;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_OFF:    if (r_pg_int) w_next = S_SETTLE;
      S_SETTLE: if (!r_pg_int) w_next = S_OFF;
                else if (r_cnt >= c_settle_last) w_next = S_LATCH;
      S_LATCH:  if (!r_pg_int) w_next = S_OFF;
                else if (image_load_ack) w_next = S_WARMUP;
                else if (r_cnt >= c_load_last) w_next = S_FAULT;
      S_WARMUP: if (!r_pg_int) w_next = S_OFF;
                else if (r_cnt >= c_warm_last) w_next = S_RUN;
      S_RUN:    if (!r_pg_int || w_hs_trigger) w_next = S_DRAIN;
      S_DRAIN:  if (!bubble_busy || (r_cnt >= c_drain_last)) w_next = w_drain_exit;
      S_FAULT:  if (!r_pg_int) w_next = S_OFF;
      default:  w_next = S_OFF;
    endcase
  end

  always_ff @(posedge master_clock or posedge master_reset) begin
    if (master_reset) begin
      r_state <= S_OFF;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state)
        r_cnt <= '0;
      else if (r_cnt != c_cnt_max)
        r_cnt <= r_cnt + CNT_WIDTH'(1);
    end
  end

  // READY lags the state by one cycle so it stays up through the DRAIN entry cycle
  always_ff @(posedge master_clock or posedge master_reset) begin
    if (master_reset) begin
      r_temp_low <= 1'b0;
      r_enable_n <= 1'b1;
      r_image    <= '0;
      r_req      <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      r_temp_low <= (r_state == S_RUN);
      r_enable_n <= !((w_next == S_RUN) || (w_next == S_DRAIN));
      r_req      <= (r_state == S_LATCH) && (w_next == S_LATCH);
      r_fault    <= (w_next == S_FAULT);
      if ((w_next == S_LATCH) && (r_state != S_LATCH))
        r_image <= ~w_dip_synced;
    end
  end

  assign temperature_low      = r_temp_low;
  assign bubble_module_enable = r_enable_n;
  assign image_number         = r_image;
  assign image_load_req       = r_req;
  assign seq_fault            = r_fault;
  assign seq_state            = r_state;

endmodule

`default_nettype wire

// File: tb/tb_power_sequencer.sv
// ============================================================================
// Module   : tb_power_sequencer
// Purpose  : Scoreboard bench for power_sequencer; state changes are matched
//            against an expected queue filled by the stimulus process.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_power_sequencer;

  localparam int SYNC    = 3;
  localparam int DEB     = 4;
  localparam int SETTLE  = 8;
  localparam int WARM    = 8;
  localparam int LOADTO  = 32;
  localparam int DRAINTO = 16;
  localparam int ACK_DLY = 5;
  localparam int LAT_NOM = SYNC + DEB + SETTLE + ACK_DLY + WARM + 3;

  localparam logic [2:0] ST_OFF    = 3'd0;
  localparam logic [2:0] ST_SETTLE = 3'd1;
  localparam logic [2:0] ST_LATCH  = 3'd2;
  localparam logic [2:0] ST_WARMUP = 3'd3;
  localparam logic [2:0] ST_RUN    = 3'd4;
  localparam logic [2:0] ST_DRAIN  = 3'd5;
  localparam logic [2:0] ST_FAULT  = 3'd6;

  logic       master_clock = 1'b0;
  logic       master_reset = 1'b0;
  logic       power_good = 1'b0;
  logic [2:0] image_dip_switch = 3'b101;
  logic       image_load_ack = 1'b0;
  logic       bubble_busy = 1'b0;
  logic       temperature_low;
  logic       bubble_module_enable;
  logic [2:0] image_number;
  logic       image_load_req;
  logic       seq_fault;
  logic [2:0] seq_state;

  typedef struct packed {
    logic [2:0] st;
    logic       en;
    logic       req;
    logic       flt;
    logic [2:0] img;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic       mon_en = 1'b0;
  logic [2:0] mon_prev = 3'd0;

  power_sequencer #(
    .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .SETTLE_CYCLES(SETTLE),
    .WARMUP_CYCLES(WARM), .LOAD_TIMEOUT_CYCLES(LOADTO),
    .DRAIN_TIMEOUT_CYCLES(DRAINTO), .IMAGE_BITS(3), .CNT_WIDTH(29)
  ) dut (
    .master_clock(master_clock), .master_reset(master_reset),
    .power_good(power_good), .image_dip_switch(image_dip_switch),
    .image_load_ack(image_load_ack), .bubble_busy(bubble_busy),
    .temperature_low(temperature_low), .bubble_module_enable(bubble_module_enable),
    .image_number(image_number), .image_load_req(image_load_req),
    .seq_fault(seq_fault), .seq_state(seq_state)
  );

  always #5 master_clock = ~master_clock;
  always @(posedge master_clock) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for event", nm);
  endtask

  task automatic push(input logic [2:0] st, input logic en, input logic req,
                      input logic flt, input logic [2:0] img);
    exp_t e;
    e.st = st; e.en = en; e.req = req; e.flt = flt; e.img = img;
    sb.push_back(e);
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string nm);
    int n;
    n = 0;
    while (seq_state !== s && n < budget) begin
      @(negedge master_clock);
      n++;
    end
    if (seq_state !== s) timeout(nm);
  endtask

  // Full power-up to RUN with the loader answering ack_dly cycles after req
  task automatic power_up(input int ack_dly, input logic [2:0] img_before,
                          input logic [2:0] img_after, output int lat);
    int n, start, req_hi;
    push(ST_SETTLE, 1'b1, 1'b0, 1'b0, img_before);
    push(ST_LATCH,  1'b1, 1'b0, 1'b0, img_after);
    push(ST_WARMUP, 1'b1, 1'b0, 1'b0, img_after);
    push(ST_RUN,    1'b0, 1'b0, 1'b0, img_after);
    start = cyc;
    power_good = 1'b1;
    n = 0;
    while (image_load_req !== 1'b1 && n < 80) begin
      @(negedge master_clock);
      n++;
    end
    if (image_load_req !== 1'b1) timeout("req_rise");
    req_hi = 1;
    repeat (ack_dly - 1) begin
      @(negedge master_clock);
      if (image_load_req === 1'b1) req_hi++;
    end
    image_load_ack = 1'b1;
    @(negedge master_clock);
    check("req_drop_on_ack", 32'(image_load_req), 32'(0));
    image_load_ack = 1'b0;
    check("req_high_cycles", 32'(req_hi), 32'(ack_dly));
    n = 0;
    while (temperature_low !== 1'b1 && n < 80) begin
      @(negedge master_clock);
      n++;
    end
    if (temperature_low !== 1'b1) timeout("ready_rise");
    lat = cyc - start;
  endtask

  // Monitor: every change of seq_state consumes one scoreboard entry
  initial begin
    exp_t e, a;
    forever begin
      @(negedge master_clock);
      if (mon_en && seq_state !== mon_prev) begin
        a.st = seq_state; a.en = bubble_module_enable; a.req = image_load_req;
        a.flt = seq_fault; a.img = image_number;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_change: got state %0d expected no change", seq_state);
        end else begin
          e = sb.pop_front();
          if (a !== e) begin
            errors++;
            $display("FAIL sb_state_change: got st=%0d en=%b req=%b flt=%b img=%b expected st=%0d en=%b req=%b flt=%b img=%b",
                     a.st, a.en, a.req, a.flt, a.img, e.st, e.en, e.req, e.flt, e.img);
          end
        end
        mon_prev = seq_state;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, n;
    logic [2:0] cur_img;
    #1 master_reset = 1'b1;
    repeat (3) @(negedge master_clock);
    check("rst_temperature_low", 32'(temperature_low), 32'(0));
    check("rst_enable", 32'(bubble_module_enable), 32'(1));
    check("rst_image_number", 32'(image_number), 32'(0));
    check("rst_load_req", 32'(image_load_req), 32'(0));
    check("rst_seq_fault", 32'(seq_fault), 32'(0));
    check("rst_seq_state", 32'(seq_state), 32'(ST_OFF));
    master_reset = 1'b0;
    mon_en = 1'b1;

    // Bounce shorter than the debounce window never reaches pg_int
    for (int i = 0; i < 10; i++) begin
      power_good = ~power_good;
      repeat (2) @(negedge master_clock);
    end
    power_good = 1'b0;
    repeat (8) @(negedge master_clock);
    check("bounce_state", 32'(seq_state), 32'(ST_OFF));
    check("bounce_enable", 32'(bubble_module_enable), 32'(1));
    check("bounce_ready", 32'(temperature_low), 32'(0));
    check("bounce_req", 32'(image_load_req), 32'(0));

    // Nominal power-up with DIP=101
    power_up(ACK_DLY, 3'b000, 3'b010, lat);
    check("nominal_image", 32'(image_number), 32'(3'b010));
    check("nominal_state", 32'(seq_state), 32'(ST_RUN));
    check("nominal_enable", 32'(bubble_module_enable), 32'(0));
    checks++;
    if (lat < LAT_NOM - 3 || lat > LAT_NOM + 3) begin
      errors++;
      $display("FAIL ready_latency: got %0d expected %0d +/-3", lat, LAT_NOM);
    end

    // Drain released by bubble_busy falling
    bubble_busy = 1'b1;
    push(ST_DRAIN, 1'b0, 1'b0, 1'b0, 3'b010);
    push(ST_OFF,   1'b1, 1'b0, 1'b0, 3'b010);
    power_good = 1'b0;
    wait_state(ST_DRAIN, 40, "drain_entry");
    @(negedge master_clock);
    check("drain_ready_low", 32'(temperature_low), 32'(0));
    check("drain_enable_held", 32'(bubble_module_enable), 32'(0));
    repeat (5) @(negedge master_clock);
    check("drain_enable_before_idle", 32'(bubble_module_enable), 32'(0));
    bubble_busy = 1'b0;
    @(negedge master_clock);
    check("drain_enable_after_idle", 32'(bubble_module_enable), 32'(1));
    check("drain_off_state", 32'(seq_state), 32'(ST_OFF));

    // Drain released by timeout with busy stuck high
    power_up(3, 3'b010, 3'b010, lat);
    bubble_busy = 1'b1;
    push(ST_DRAIN, 1'b0, 1'b0, 1'b0, 3'b010);
    push(ST_OFF,   1'b1, 1'b0, 1'b0, 3'b010);
    power_good = 1'b0;
    wait_state(ST_DRAIN, 40, "drain2_entry");
    n = 0;
    while (bubble_module_enable !== 1'b1 && n < 40) begin
      @(negedge master_clock);
      n++;
    end
    check("drain_timeout_cycles", 32'(n), 32'(DRAINTO));
    bubble_busy = 1'b0;

    // Load timeout into FAULT
    push(ST_SETTLE, 1'b1, 1'b0, 1'b0, 3'b010);
    push(ST_LATCH,  1'b1, 1'b0, 1'b0, 3'b010);
    push(ST_FAULT,  1'b1, 1'b0, 1'b1, 3'b010);
    push(ST_OFF,    1'b1, 1'b0, 1'b0, 3'b010);
    power_good = 1'b1;
    wait_state(ST_LATCH, 60, "fault_latch_entry");
    n = 0;
    while (seq_state !== ST_FAULT && n < 60) begin
      @(negedge master_clock);
      n++;
    end
    check("latch_timeout_cycles", 32'(n), 32'(LOADTO));
    check("fault_flag", 32'(seq_fault), 32'(1));
    check("fault_enable", 32'(bubble_module_enable), 32'(1));
    power_good = 1'b0;
    wait_state(ST_OFF, 40, "fault_exit");
    check("fault_cleared", 32'(seq_fault), 32'(0));

    // Asynchronous reset in the middle of LATCH
    push(ST_SETTLE, 1'b1, 1'b0, 1'b0, 3'b010);
    push(ST_LATCH,  1'b1, 1'b0, 1'b0, 3'b010);
    push(ST_OFF,    1'b1, 1'b0, 1'b0, 3'b000);
    power_good = 1'b1;
    n = 0;
    while (image_load_req !== 1'b1 && n < 80) begin
      @(negedge master_clock);
      n++;
    end
    if (image_load_req !== 1'b1) timeout("midlatch_req");
    #2 master_reset = 1'b1;
    #1;
    check("async_rst_req", 32'(image_load_req), 32'(0));
    check("async_rst_state", 32'(seq_state), 32'(ST_OFF));
    check("async_rst_image", 32'(image_number), 32'(0));
    power_good = 1'b0;
    repeat (3) @(negedge master_clock);
    master_reset = 1'b0;

    // DIP change while running
    power_up(4, 3'b000, 3'b010, lat);
    image_dip_switch = 3'b110;
`ifdef IMAGE_HOTSWAP_EN
    push(ST_DRAIN,  1'b0, 1'b0, 1'b0, 3'b010);
    push(ST_SETTLE, 1'b1, 1'b0, 1'b0, 3'b010);
    push(ST_LATCH,  1'b1, 1'b0, 1'b0, 3'b001);
    push(ST_WARMUP, 1'b1, 1'b0, 1'b0, 3'b001);
    push(ST_RUN,    1'b0, 1'b0, 1'b0, 3'b001);
    wait_state(ST_LATCH, 80, "hotswap_relatch");
    check("hotswap_image", 32'(image_number), 32'(3'b001));
    image_load_ack = 1'b1;
    @(negedge master_clock);
    image_load_ack = 1'b0;
    wait_state(ST_RUN, 40, "hotswap_run");
    cur_img = 3'b001;
`else
    repeat (30) @(negedge master_clock);
    check("dip_ignored_state", 32'(seq_state), 32'(ST_RUN));
    check("dip_ignored_image", 32'(image_number), 32'(3'b010));
    check("dip_ignored_ready", 32'(temperature_low), 32'(1));
    cur_img = 3'b010;
`endif

    push(ST_DRAIN, 1'b0, 1'b0, 1'b0, cur_img);
    push(ST_OFF,   1'b1, 1'b0, 1'b0, cur_img);
    power_good = 1'b0;
    wait_state(ST_OFF, 60, "final_off");
    repeat (3) @(negedge master_clock);
    check("scoreboard_drained", 32'(sb.size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
